// File: rtl/seq_word_serializer_pkg.sv
`default_nettype none
// seq_ser_pkg: state encoding, defaults and sizing constants for seq_word_serializer.
package seq_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GAP   = 2'b01,
    SHIFT = 2'b10
  } ser_state_e;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_GAP_CYCLES = 1;
  localparam int GAP_CYCLES_MIN = 1;
  localparam int GAP_CYCLES_MAX = 15;
  localparam int FIFO_DEPTH     = 2;
  localparam int GAP_CNT_W      = 4;

endpackage
`default_nettype wire

// File: rtl/seq_word_serializer_if.sv
`default_nettype none
// seq_word_serializer_if: word handshake in, serial bit stream and stage control out.
interface seq_word_serializer_if #(
  parameter int WIDTH = 32
) ();
  localparam int IDX_W = $clog2(WIDTH);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             x;
  logic             x_valid;
  logic             stage_clr;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] bit_idx;

  modport master (
    output in_valid, in_data,
    input  in_ready, x, x_valid, stage_clr, busy, done, bit_idx
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, x, x_valid, stage_clr, busy, done, bit_idx
  );
endinterface
`default_nettype wire

// File: rtl/seq_word_serializer_word_fifo2.sv
`default_nettype none
// word_fifo2: two-entry word FIFO; head is always a register (no fall-through).
module word_fifo2
  import seq_ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem0_q;
  logic [WIDTH-1:0] mem1_q;
  logic [1:0]       count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == 2'(FIFO_DEPTH));
  assign empty_o = (count_q == 2'd0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem0_q;

  // mem0_q is the head; a pop shifts mem1_q forward so ordering is kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) mem0_q <= wdata_i;
          else                 mem1_q <= wdata_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          mem0_q  <= mem1_q;
          count_q <= count_q - 2'd1;
        end
        // Both only possible with exactly one entry held.
        2'b11:   mem0_q <= wdata_i;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_word_serializer.sv
`default_nettype none
// seq_word_serializer: buffers words and shifts them out MSB-first,
// holding the downstream stage cleared for GAP_CYCLES before every word.
module seq_word_serializer
  import seq_ser_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_word_serializer_if.slave bus
);

  localparam int                   IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES - 1);

  ser_state_e           state_q, state_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 done_q, done_d;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WIDTH-1:0]     fifo_rdata;

  word_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.in_valid),
    .wdata_i (bus.in_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    gap_d    = gap_q;
    idx_d    = idx_q;
    fifo_pop = 1'b0;
    done_d   = (state_q == SHIFT) && (idx_q == '0);

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          gap_d    = GAP_LOAD;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = SHIFT;
          idx_d   = LAST_IDX;
        end else begin
          gap_d = gap_q - GAP_CNT_W'(1);
        end
      end
      SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        idx_d   = idx_q - IDX_W'(1);
        if (idx_q == '0) begin
          idx_d = '0;
          // Chain straight into the next word's gap when one is waiting.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_rdata;
            gap_d    = GAP_LOAD;
            state_d  = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.x         = (state_q == SHIFT) && shreg_q[WIDTH-1];
  assign bus.x_valid   = (state_q == SHIFT);
  assign bus.stage_clr = (state_q != SHIFT);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.bit_idx   = idx_q;

endmodule
`default_nettype wire
